// File: rtl/jtcop_mcubus_pkg.sv
// Shared definitions for the 68000 <-> i8751 mailbox bridge.
// Port-2 strobe bit positions and the per-channel register record.
package jtcop_mcubus_pkg;

  localparam int P2_INTEN = 3;
  localparam int P2_RDHI  = 4;
  localparam int P2_RDLO  = 5;
  localparam int P2_WRLO  = 6;
  localparam int P2_WRHI  = 7;

  typedef struct packed {
    logic [15:0] m2s;
    logic [15:0] s2m;
    logic        pend;
    logic        vlo;
    logic        vhi;
  } ch_word_t;

endpackage

// File: rtl/jtcop_mcubus_ch.sv
// One mailbox channel: main->MCU word, MCU->main word and flags.
// Same-cycle set/clear conflicts are resolved here, set wins.
module jtcop_mcubus_ch
  import jtcop_mcubus_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        main_wr_i,
  input  logic        main_rd_i,
  input  logic [1:0]  main_dsn_i,
  input  logic [15:0] main_din_i,
  input  logic        mcu_rdlo_i,
  input  logic        mcu_wrlo_i,
  input  logic        mcu_wrhi_i,
  input  logic [7:0]  mcu_din_i,
  output ch_word_t    word_o
);

  ch_word_t word_q, word_d;

  // Next-state: byte-lane writes, flag set beats flag clear.
  always_comb begin
    word_d = word_q;
    if (main_wr_i) begin
      if (!main_dsn_i[1]) word_d.m2s[15:8] = main_din_i[15:8];
      if (!main_dsn_i[0]) word_d.m2s[7:0]  = main_din_i[7:0];
      word_d.pend = 1'b1;
    end else if (mcu_rdlo_i) begin
      word_d.pend = 1'b0;
    end
    if (mcu_wrlo_i) begin
      word_d.s2m[7:0] = mcu_din_i;
      word_d.vlo      = 1'b1;
    end else if (main_rd_i) begin
      word_d.vlo = 1'b0;
    end
    if (mcu_wrhi_i) begin
      word_d.s2m[15:8] = mcu_din_i;
      word_d.vhi       = 1'b1;
    end else if (main_rd_i) begin
      word_d.vhi = 1'b0;
    end
  end

  // Channel state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) word_q <= '0;
    else       word_q <= word_d;
  end

  assign word_o = word_q;

endmodule

// File: rtl/jtcop_mcubus.sv
// Multi-channel mailbox between the 68000 bus and the i8751 ports.
// Owns strobe edge detection, the read muxes and both interrupts.
module jtcop_mcubus
  import jtcop_mcubus_pkg::*;
#(
  parameter int CH       = 4,
  parameter int CHW      = 3,
  parameter int MAIN_IRQ = 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [CH-1:0]  main_sel,
  input  logic           main_rnw,
  input  logic [1:0]     main_dsn,
  input  logic [15:0]    main_din,
  output logic [15:0]    main_dout,
  output logic           main_irqn,
  input  logic [7:0]     mcu_p0o,
  input  logic [7:0]     mcu_p2o,
  input  logic [CHW-1:0] mcu_chsel,
  output logic [7:0]     mcu_p0i,
  output logic           mcu_intn,
  output logic [CH-1:0]  pend
);

  logic [7:0]    p2l_q;
  logic [CH-1:0] msl_q;
  logic [7:0]    p0i_q, p0i_d;
  logic          intn_q, intn_d;
  logic          irqn_q, irqn_d;

  logic [7:0]    ev;
  logic [CH-1:0] wr, mrd, hit, valid;
  logic [15:0]   rd_word;
  ch_word_t      words [CH];

  assign ev  = mcu_p2o & ~p2l_q;
  assign wr  = main_sel & ~msl_q & {CH{~main_rnw}};
  assign mrd = ~main_sel & msl_q & {CH{main_rnw}};

  // Channel decode; indices beyond CH match nothing.
  always_comb begin
    hit = '0;
    for (int i = 0; i < CH; i++)
      hit[i] = (mcu_chsel == CHW'(i));
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    jtcop_mcubus_ch u_ch (
      .clk        (clk),
      .rstn       (rstn),
      .main_wr_i  (wr[g]),
      .main_rd_i  (mrd[g]),
      .main_dsn_i (main_dsn),
      .main_din_i (main_din),
      .mcu_rdlo_i (ev[P2_RDLO] & hit[g]),
      .mcu_wrlo_i (ev[P2_WRLO] & hit[g]),
      .mcu_wrhi_i (ev[P2_WRHI] & hit[g]),
      .mcu_din_i  (mcu_p0o),
      .word_o     (words[g])
    );
    assign pend[g]  = words[g].pend;
    assign valid[g] = words[g].vlo & words[g].vhi;
  end

  // MCU-side read mux; out-of-range channel reads as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < CH; i++)
      if (hit[i]) rd_word = words[i].m2s;
  end

  // Main-side read mux, lowest selected channel first.
  always_comb begin
    main_dout = '0;
    for (int i = CH - 1; i >= 0; i--)
      if (main_sel[i]) main_dout = words[i].s2m;
  end

  // Next-state for port-0 data and both interrupt lines.
  always_comb begin
    p0i_d = p0i_q;
    if (ev[P2_RDLO])      p0i_d = rd_word[7:0];
    else if (ev[P2_RDHI]) p0i_d = rd_word[15:8];
    intn_d = intn_q;
    if (!mcu_p2o[P2_INTEN]) intn_d = 1'b1;
    else if (|wr)           intn_d = 1'b0;
    irqn_d = (MAIN_IRQ != 0) ? ~|valid : 1'b1;
  end

  // Edge-detect history and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p2l_q  <= 8'hFF;
      msl_q  <= '0;
      p0i_q  <= '0;
      intn_q <= 1'b1;
      irqn_q <= 1'b1;
    end else begin
      p2l_q  <= mcu_p2o;
      msl_q  <= main_sel;
      p0i_q  <= p0i_d;
      intn_q <= intn_d;
      irqn_q <= irqn_d;
    end
  end

  assign mcu_p0i   = p0i_q;
  assign mcu_intn  = intn_q;
  assign main_irqn = irqn_q;

endmodule

// File: tb/tb_jtcop_mcubus.sv
// Directed self-checking bench for jtcop_mcubus (CH = 4).
// Linear stimulus, immediate assertions at every check point.
module tb_jtcop_mcubus;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  main_sel;
  logic        main_rnw;
  logic [1:0]  main_dsn;
  logic [15:0] main_din;
  logic [15:0] main_dout;
  logic        main_irqn;
  logic [7:0]  mcu_p0o;
  logic [7:0]  mcu_p2o;
  logic [2:0]  mcu_chsel;
  logic [7:0]  mcu_p0i;
  logic        mcu_intn;
  logic [3:0]  pend;

  int checks   = 0;
  int failures = 0;
  logic [7:0] p2base;

  jtcop_mcubus #(.CH(4), .CHW(3), .MAIN_IRQ(1)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .main_sel  (main_sel),
    .main_rnw  (main_rnw),
    .main_dsn  (main_dsn),
    .main_din  (main_din),
    .main_dout (main_dout),
    .main_irqn (main_irqn),
    .mcu_p0o   (mcu_p0o),
    .mcu_p2o   (mcu_p2o),
    .mcu_chsel (mcu_chsel),
    .mcu_p0i   (mcu_p0i),
    .mcu_intn  (mcu_intn),
    .pend      (pend)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic main_write(input int ch, input logic [1:0] dsn,
                            input logic [15:0] d);
    main_sel = 4'(1 << ch);
    main_rnw = 1'b0;
    main_dsn = dsn;
    main_din = d;
    step(1);
    main_sel = 4'h0;
    step(1);
  endtask

  task automatic pulse(input int b);
    mcu_p2o = p2base | 8'(1 << b);
    step(1);
    mcu_p2o = p2base;
    step(1);
  endtask

  initial begin
    rstn = 1'b0; main_sel = '0; main_rnw = 1'b1; main_dsn = 2'b11;
    main_din = '0; mcu_p0o = '0; mcu_p2o = 8'hFF; mcu_chsel = '0;
    p2base = 8'h08;
    step(2);
    rstn = 1'b1;
    step(2);
    chk("rst_p0i", 16'(mcu_p0i), 16'h0000);
    chk("rst_pend", 16'(pend), 16'h0000);
    chk("rst_intn", 16'(mcu_intn), 16'h0001);
    chk("rst_irqn", 16'(main_irqn), 16'h0001);
    mcu_p2o = p2base;
    step(2);
    chk("p2ff_pend", 16'(pend), 16'h0000);
    chk("p2ff_intn", 16'(mcu_intn), 16'h0001);
    chk("idle_dout", main_dout, 16'h0000);

    // 1: main write ch2, MCU reads both halves
    main_write(2, 2'b00, 16'hA55A);
    chk("t1_pend", 16'(pend), 16'h0004);
    chk("t1_intn", 16'(mcu_intn), 16'h0000);
    mcu_chsel = 3'd2;
    pulse(4);
    chk("t1_rdhi", 16'(mcu_p0i), 16'h00A5);
    chk("t1_pend_hold", 16'(pend), 16'h0004);
    pulse(5);
    chk("t1_rdlo", 16'(mcu_p0i), 16'h005A);
    chk("t1_pend_clr", 16'(pend), 16'h0000);

    // 2: low-byte-only write over FFFF
    main_write(0, 2'b00, 16'hFFFF);
    main_write(0, 2'b10, 16'h1234);
    mcu_chsel = 3'd0;
    pulse(4);
    chk("t2_hi", 16'(mcu_p0i), 16'h00FF);
    pulse(5);
    chk("t2_lo", 16'(mcu_p0i), 16'h0034);
    chk("t2_pend", 16'(pend), 16'h0000);

    // 3: MCU writes ch1, main reads it back
    mcu_chsel = 3'd1;
    mcu_p0o = 8'h3C;
    pulse(6);
    chk("t3_irqn_lo_only", 16'(main_irqn), 16'h0001);
    mcu_p0o = 8'hC3;
    mcu_p2o = p2base | 8'h80;
    step(1);
    chk("t3_irqn_lat", 16'(main_irqn), 16'h0001);
    mcu_p2o = p2base;
    step(1);
    chk("t3_irqn_set", 16'(main_irqn), 16'h0000);
    main_sel = 4'b0010;
    main_rnw = 1'b1;
    #1;
    chk("t3_dout", main_dout, 16'hC33C);
    step(1);
    main_sel = 4'b0000;
    step(1);
    chk("t3_irqn_lat2", 16'(main_irqn), 16'h0000);
    step(1);
    chk("t3_irqn_clr", 16'(main_irqn), 16'h0001);

    // 4: same-cycle main write and MCU rd lo on ch3
    main_write(3, 2'b00, 16'hBEEF);
    mcu_chsel = 3'd3;
    main_sel = 4'b1000;
    main_rnw = 1'b0;
    main_dsn = 2'b00;
    main_din = 16'h1111;
    mcu_p2o = p2base | 8'h20;
    step(1);
    main_sel = 4'b0000;
    mcu_p2o = p2base;
    step(1);
    chk("t4_pend", 16'(pend), 16'h0008);
    chk("t4_old", 16'(mcu_p0i), 16'h00EF);
    pulse(5);
    chk("t4_new", 16'(mcu_p0i), 16'h0011);
    chk("t4_pend_clr", 16'(pend), 16'h0000);
    p2base = 8'h00;
    mcu_p2o = p2base;
    step(1);
    chk("t4_intn_clr", 16'(mcu_intn), 16'h0001);
    main_write(0, 2'b00, 16'h5555);
    chk("t4_intn_mask", 16'(mcu_intn), 16'h0001);
    p2base = 8'h08;
    mcu_p2o = p2base;
    step(1);
    chk("t4_intn_idle", 16'(mcu_intn), 16'h0001);
    mcu_chsel = 3'd0;
    pulse(5);
    chk("t4_ch0", 16'(mcu_p0i), 16'h0055);

    // 5: asynchronous reset mid-transfer
    main_write(1, 2'b00, 16'h0F0F);
    chk("t5_pend", 16'(pend), 16'h0002);
    chk("t5_intn", 16'(mcu_intn), 16'h0000);
    mcu_chsel = 3'd2;
    mcu_p0o = 8'h11;
    pulse(6);
    mcu_p0o = 8'h22;
    pulse(7);
    step(1);
    chk("t5_irqn", 16'(main_irqn), 16'h0000);
    main_sel = 4'b0100;
    main_rnw = 1'b1;
    mcu_p2o = p2base | 8'h10;
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_ar_pend", 16'(pend), 16'h0000);
    chk("t5_ar_intn", 16'(mcu_intn), 16'h0001);
    chk("t5_ar_irqn", 16'(main_irqn), 16'h0001);
    chk("t5_ar_p0i", 16'(mcu_p0i), 16'h0000);
    mcu_p2o = 8'hFF;
    main_sel = 4'b0000;
    step(2);
    rstn = 1'b1;
    step(2);
    chk("t5_rel_pend", 16'(pend), 16'h0000);
    chk("t5_rel_p0i", 16'(mcu_p0i), 16'h0000);
    chk("t5_rel_intn", 16'(mcu_intn), 16'h0001);
    mcu_p2o = p2base;
    step(1);

    // 6: out-of-range channel index
    main_write(0, 2'b00, 16'h7788);
    mcu_chsel = 3'd0;
    pulse(5);
    chk("t6_ch0", 16'(mcu_p0i), 16'h0088);
    mcu_chsel = 3'd5;
    pulse(4);
    chk("t6_rdhi", 16'(mcu_p0i), 16'h0000);
    mcu_p0o = 8'hAA;
    pulse(6);
    pulse(7);
    step(1);
    chk("t6_irqn", 16'(main_irqn), 16'h0001);
    for (int i = 0; i < 4; i++) begin
      main_sel = 4'(1 << i);
      main_rnw = 1'b1;
      #1;
      chk($sformatf("t6_dout%0d", i), main_dout, 16'h0000);
      step(1);
      main_sel = 4'b0000;
      step(1);
    end
    chk("t6_pend", 16'(pend), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
